time_display: RTL and testbench



---
 rtl/time_display_pkg.sv | 46 ++++
 rtl/time_display_bin2bcd.sv | 53 +++++
 rtl/time_display.sv | 171 +++++++++++++++++
 tb/tb_time_display.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_display_pkg.sv
// Shared constants, state encoding and segment decoding for the HH:MM:SS display.
package time_display_pkg;

  // Field widths of the incoming binary time value
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 7;

  // Active-low segment patterns, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Refresh sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP  = 3'd1,
    CV_S = 3'd2,
    CV_M = 3'd3,
    CV_H = 3'd4,
    UPD  = 3'd5
  } state_t;

  // BCD digit to segment pattern; non-decimal codes show as blank
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/time_display_bin2bcd.sv
// Sequential double-dabble converter: 7-bit binary to two BCD digits in 8 cycles.
// Cycle 0 (start) loads the operand, cycles 1..7 each apply add-3 then shift;
// the final shift is combinational so the result is valid while done is high.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [7:0] bcd,
  output logic       ovf
);

  logic [14:0] shreg;
  logic [14:0] step_next;
  logic [2:0]  step_cnt;
  logic        active;

  // One double-dabble step on the current working register
  always_comb begin
    step_next = shreg;
    if (step_next[10:7] >= 4'd5) step_next[10:7] = step_next[10:7] + 4'd3;
    if (step_next[14:11] >= 4'd5) step_next[14:11] = step_next[14:11] + 4'd3;
    step_next = {step_next[13:0], 1'b0};
  end

  // Load on start, then step six times into the register; the seventh step is consumed live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      step_cnt <= '0;
      active   <= 1'b0;
      ovf      <= 1'b0;
    end else if (start) begin
      shreg    <= {8'd0, bin};
      step_cnt <= 3'd1;
      active   <= 1'b1;
      ovf      <= (bin >= 7'd100);
    end else if (active) begin
      if (step_cnt == 3'd7) begin
        active   <= 1'b0;
        step_cnt <= '0;
      end else begin
        shreg    <= step_next;
        step_cnt <= step_cnt + 3'd1;
      end
    end
  end

  assign done = active && (step_cnt == 3'd7);
  assign bcd  = step_next[14:7];

endmodule

// File: rtl/time_display.sv
// Periodically snapshots binary HH:MM:SS, converts each field to BCD with one
// shared sequential converter and drives six registered active-low 7-seg digits.
module time_display
  import time_display_pkg::*;
#(
  parameter logic [31:0] REFRESH_CYCLES  = 32'd500_000,
  parameter logic        BLANK_LEAD_HOUR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_seconds,
  input  logic [5:0] i_minutes,
  input  logic [6:0] i_hours,
  output logic [6:0] o_hex0,
  output logic [6:0] o_hex1,
  output logic [6:0] o_hex2,
  output logic [6:0] o_hex3,
  output logic [6:0] o_hex4,
  output logic [6:0] o_hex5,
  output logic       o_busy
);

  state_t state;
  state_t next_state;

  logic [31:0]      refresh_cnt;
  logic             tick;
  logic             pending;
  logic [2:0]       phase;

  logic [SEC_W-1:0] sec_snap;
  logic [MIN_W-1:0] min_snap;
  logic [HR_W-1:0]  hr_snap;

  logic [7:0]       bcd_s;
  logic [7:0]       bcd_m;
  logic [7:0]       bcd_h;
  logic             hr_ovf;

  logic             cv_start;
  logic [6:0]       cv_bin;
  logic             cv_done;
  logic [7:0]       cv_bcd;
  logic             cv_ovf;

  // Free-running refresh divider; it keeps counting during a refresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
    end else if (refresh_cnt == REFRESH_CYCLES - 32'd1) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  assign tick = (refresh_cnt == REFRESH_CYCLES - 32'd1);

  // State register; busy is registered from the next state so it lines up with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      o_busy <= 1'b0;
    end else begin
      state  <= next_state;
      o_busy <= (next_state != IDLE);
    end
  end

  // Next-state logic; ticks arriving outside IDLE are simply ignored
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick || pending) next_state = CAP;
      CAP:     next_state = CV_S;
      CV_S:    if (cv_done) next_state = CV_M;
      CV_M:    if (cv_done) next_state = CV_H;
      CV_H:    if (cv_done) next_state = UPD;
      UPD:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Converter control: start pulse on the first cycle of each conversion, operand mux by field
  always_comb begin
    cv_start = 1'b0;
    cv_bin   = '0;
    case (state)
      CV_S: begin
        cv_start = (phase == 3'd0);
        cv_bin   = {1'b0, sec_snap};
      end
      CV_M: begin
        cv_start = (phase == 3'd0);
        cv_bin   = {1'b0, min_snap};
      end
      CV_H: begin
        cv_start = (phase == 3'd0);
        cv_bin   = hr_snap;
      end
      default: begin
        cv_start = 1'b0;
        cv_bin   = '0;
      end
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cv_start),
    .bin   (cv_bin),
    .done  (cv_done),
    .bcd   (cv_bcd),
    .ovf   (cv_ovf)
  );

  // Datapath: phase counter, input snapshot, per-field results and the displayed digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b1;
      phase    <= '0;
      sec_snap <= '0;
      min_snap <= '0;
      hr_snap  <= '0;
      bcd_s    <= '0;
      bcd_m    <= '0;
      bcd_h    <= '0;
      hr_ovf   <= 1'b0;
      o_hex0   <= SEG_BLANK;
      o_hex1   <= SEG_BLANK;
      o_hex2   <= SEG_BLANK;
      o_hex3   <= SEG_BLANK;
      o_hex4   <= SEG_BLANK;
      o_hex5   <= SEG_BLANK;
    end else begin
      phase <= (next_state != state) ? 3'd0 : phase + 3'd1;

      if (state == IDLE) pending <= 1'b0;

      if (state == CAP) begin
        sec_snap <= i_seconds;
        min_snap <= i_minutes;
        hr_snap  <= i_hours;
      end

      if (state == CV_S && cv_done) bcd_s <= cv_bcd;
      if (state == CV_M && cv_done) bcd_m <= cv_bcd;
      if (state == CV_H && cv_done) begin
        bcd_h  <= cv_bcd;
        hr_ovf <= cv_ovf;
      end

      if (state == UPD) begin
        o_hex0 <= seg_decode(bcd_s[3:0]);
        o_hex1 <= seg_decode(bcd_s[7:4]);
        o_hex2 <= seg_decode(bcd_m[3:0]);
        o_hex3 <= seg_decode(bcd_m[7:4]);
        if (hr_ovf) begin
          o_hex4 <= SEG_DASH;
          o_hex5 <= SEG_DASH;
        end else begin
          o_hex4 <= seg_decode(bcd_h[3:0]);
          if (BLANK_LEAD_HOUR && (bcd_h[7:4] == 4'd0)) o_hex5 <= SEG_BLANK;
          else                                         o_hex5 <= seg_decode(bcd_h[7:4]);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display: two instances (leading-hour blanking on
// and off) compared every cycle against a behavioural model of the refresh schedule.
module tb_time_display;

  localparam int RC = 50;
  localparam logic [6:0] DIG [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [6:0] hr  = '0;

  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       busy;
  logic [6:0] nb_hex0, nb_hex1, nb_hex2, nb_hex3, nb_hex4, nb_hex5;
  logic       nb_busy;

  always #5 clk = ~clk;

  time_display #(.REFRESH_CYCLES(32'(RC)), .BLANK_LEAD_HOUR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_seconds(sec), .i_minutes(min), .i_hours(hr),
    .o_hex0(hex0), .o_hex1(hex1), .o_hex2(hex2), .o_hex3(hex3),
    .o_hex4(hex4), .o_hex5(hex5), .o_busy(busy)
  );

  time_display #(.REFRESH_CYCLES(32'(RC)), .BLANK_LEAD_HOUR(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .i_seconds(sec), .i_minutes(min), .i_hours(hr),
    .o_hex0(nb_hex0), .o_hex1(nb_hex1), .o_hex2(nb_hex2), .o_hex3(nb_hex3),
    .o_hex4(nb_hex4), .o_hex5(nb_hex5), .o_busy(nb_busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: k counts rising edges since reset release; a refresh that
  // starts in cycle s is busy after edges s+1..s+26, snapshots the inputs present
  // at edge s+2 and shows them from edge s+27 on.
  int         k;
  int         start_cyc;
  bit         active;
  int         snap_s, snap_m, snap_h;
  logic [6:0] exp_hex [0:5];
  logic [6:0] exp_nb5;

  task automatic model_blank();
    for (int i = 0; i < 6; i++) exp_hex[i] = BLANK;
    exp_nb5 = BLANK;
  endtask

  task automatic model_show(input int s, input int m, input int h);
    exp_hex[0] = DIG[s % 10];
    exp_hex[1] = DIG[s / 10];
    exp_hex[2] = DIG[m % 10];
    exp_hex[3] = DIG[m / 10];
    if (h > 99) begin
      exp_hex[4] = DASH;
      exp_hex[5] = DASH;
      exp_nb5    = DASH;
    end else begin
      exp_hex[4] = DIG[h % 10];
      exp_hex[5] = (h < 10) ? BLANK : DIG[h / 10];
      exp_nb5    = DIG[h / 10];
    end
  endtask

  function automatic bit model_busy();
    return active && (k >= start_cyc + 1) && (k <= start_cyc + 26);
  endfunction

  task automatic check_out(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  task automatic check_all();
    check_out("hex0", hex0, exp_hex[0]);
    check_out("hex1", hex1, exp_hex[1]);
    check_out("hex2", hex2, exp_hex[2]);
    check_out("hex3", hex3, exp_hex[3]);
    check_out("hex4", hex4, exp_hex[4]);
    check_out("hex5", hex5, exp_hex[5]);
    check_out("busy", {6'd0, busy}, {6'd0, model_busy()});
    check_out("nb_hex4", nb_hex4, exp_hex[4]);
    check_out("nb_hex5", nb_hex5, exp_nb5);
    check_out("nb_busy", {6'd0, nb_busy}, {6'd0, model_busy()});
  endtask

  // One clock cycle: advance the model past the edge, then compare at the falling edge
  task automatic cycle();
    @(negedge clk);
    k++;
    if (active && k == start_cyc + 2) begin
      snap_s = int'(sec);
      snap_m = int'(min);
      snap_h = int'(hr);
    end
    if (active && k == start_cyc + 27) begin
      model_show(snap_s, snap_m, snap_h);
      active = 1'b0;
    end
    check_all();
    if (!active && (k % RC) == RC - 1) begin
      active    = 1'b1;
      start_cyc = k;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance to the cycle in which the model sees a refresh begin, bounded
  task automatic run_until_start();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3 * RC && !found; i++) begin
      cycle();
      if (active && start_cyc == k) found = 1'b1;
    end
    total++;
    assert (found) else begin
      bad++;
      $error("[TB] FAIL refresh_start cycle=%0d observed=none expected=start", k);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    k         = 0;
    active    = 1'b1;
    start_cyc = 0;
    model_blank();
  endtask

  task automatic applyStimulus(input int s, input int m, input int h);
    sec = 6'(s);
    min = 6'(m);
    hr  = 7'(h);
  endtask

  initial begin
    k = 0;
    active = 1'b0;
    start_cyc = 0;
    snap_s = 0; snap_m = 0; snap_h = 0;
    model_blank();

    // Reset held: blank digits, not busy
    applyStimulus(0, 0, 0);
    repeat (3) @(negedge clk);
    check_all();
    release_reset();

    // First refresh from the pending flag, then a few idle cycles
    run(40);

    // Normal time value
    applyStimulus(59, 34, 12);
    run(2 * RC);

    // Input change mid-refresh keeps the old snapshot for this refresh
    run_until_start();
    run(5);
    applyStimulus(7, 8, 9);
    run(2 * RC);

    // Hours boundaries
    applyStimulus(0, 0, 100);
    run(RC + 5);
    applyStimulus(0, 0, 127);
    run(RC + 5);
    applyStimulus(0, 0, 99);
    run(RC + 5);
    applyStimulus(1, 2, 5);
    run(RC + 5);

    // Out-of-range seconds/minutes are shown literally
    applyStimulus(63, 60, 23);
    run(RC + 5);

    // Random values held for random durations
    for (int i = 0; i < 12; i++) begin
      applyStimulus(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 127)));
      run(int'($urandom_range(5, 70)));
    end

    // Reset in the middle of a refresh aborts it at once
    run_until_start();
    run(15);
    rst_n = 1'b0;
    #1;
    active = 1'b0;
    model_blank();
    check_all();
    repeat (2) @(negedge clk);
    applyStimulus(45, 12, 3);
    release_reset();
    run(2 * RC + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout cycle=%0d observed=running expected=finished", k);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
